// File: rtl/npc_mem_pkg.sv
// Shared types and address-decode helpers for the npc memory responder.
// The decode functions are pure so that fetch and data ports can use the same logic.
package npc_mem_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned INST_W = 32;
  localparam logic [63:0] BASE_ADDR_DEF = 64'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Range test by offset, so that base + span can never overflow.
  function automatic logic in_range(input logic [63:0] addr,
                                    input logic [63:0] base,
                                    input int unsigned aw);
    logic [63:0] span;
    span = 64'd8 << aw;
    return (addr >= base) && ((addr - base) < span);
  endfunction

  function automatic logic [63:0] word_off(input logic [63:0] addr,
                                           input logic [63:0] base);
    return (addr - base) >> 3;
  endfunction

endpackage

// File: rtl/npc_mem_resp_if.sv
// Fetch and load/store bus between the core (master) and the memory responder (slave).
interface npc_mem_resp_if;
  import npc_mem_pkg::*;

  logic                rom_ce;
  logic [63:0]         pc;
  logic [INST_W-1:0]   inst;
  logic                mem_ce;
  logic                mem_we;
  logic [63:0]         mem_raddr;
  logic [63:0]         mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic                hold_o;
  logic                addr_err_o;

  modport master (
    output rom_ce, pc, mem_ce, mem_we, mem_raddr, mem_waddr, mem_wdata,
    input  inst, mem_rdata, hold_o, addr_err_o
  );

  modport slave (
    input  rom_ce, pc, mem_ce, mem_we, mem_raddr, mem_waddr, mem_wdata,
    output inst, mem_rdata, hold_o, addr_err_o
  );
endinterface

// File: rtl/npc_mem_array.sv
// Word storage: async fetch read, enabled sync load read with clear, sync write.
module npc_mem_array #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] faddr_i,
  output logic [DATA_W-1:0] fdata_o,
  input  logic              re_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Clear wins over a read so reset and out-of-range loads return zero.
  always_ff @(posedge clk) begin
    if (clr_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign fdata_o = mem_q[faddr_i];
  assign rdata_o = rdata_q;

endmodule

// File: rtl/npc_mem_resp.sv
// Memory responder for the single-cycle core: combinational fetch, one-cycle stores,
// multi-cycle loads that stall the core through hold_o, and out-of-range flagging.
module npc_mem_resp
  import npc_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = 12,
  parameter logic [63:0] BASE_ADDR    = BASE_ADDR_DEF,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  npc_mem_resp_if.slave  bus
);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              err_q, err_d;
  logic              hold, arr_we, arr_re, arr_clr;

  logic [63:0]       f_off, r_off, w_off;
  logic              f_ok, r_ok, w_ok;
  logic [DATA_W-1:0] f_word;
  logic              unused_off;

  assign f_off = word_off(bus.pc, BASE_ADDR);
  assign r_off = word_off(bus.mem_raddr, BASE_ADDR);
  assign w_off = word_off(bus.mem_waddr, BASE_ADDR);
  assign f_ok  = bus.rom_ce && in_range(bus.pc, BASE_ADDR, ADDR_W);
  assign r_ok  = in_range(bus.mem_raddr, BASE_ADDR, ADDR_W);
  assign w_ok  = in_range(bus.mem_waddr, BASE_ADDR, ADDR_W);
  assign unused_off = ^{f_off[63:ADDR_W], r_off[63:ADDR_W], w_off[63:ADDR_W]};

  npc_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .waddr_i (w_off[ADDR_W-1:0]),
    .wdata_i (bus.mem_wdata),
    .faddr_i (f_off[ADDR_W-1:0]),
    .fdata_o (f_word),
    .re_i    (arr_re),
    .clr_i   (arr_clr),
    .raddr_i (idx_q),
    .rdata_o (bus.mem_rdata)
  );

  assign bus.inst = !f_ok    ? '0 :
                    bus.pc[2] ? f_word[63:32] : f_word[31:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    hold    = 1'b0;
    arr_we  = 1'b0;
    arr_re  = 1'b0;
    arr_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_ce) begin
          if (bus.mem_we) begin
            if (w_ok) arr_we = 1'b1;
            else      err_d  = 1'b1;
          end else if (r_ok) begin
            hold    = 1'b1;
            idx_d   = r_off[ADDR_W-1:0];
            cnt_d   = 3'(READ_LATENCY - 1);
            state_d = WAIT;
          end else begin
            err_d   = 1'b1;
            arr_clr = 1'b1;
          end
        end
      end
      WAIT: begin
        hold = 1'b1;
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          arr_re  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Reset suppresses every side effect, including the combinational stall.
    if (!rst_n) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
      err_d   = 1'b0;
      hold    = 1'b0;
      arr_we  = 1'b0;
      arr_re  = 1'b0;
      arr_clr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    idx_q <= idx_d;
  end

  assign bus.hold_o     = hold;
  assign bus.addr_err_o = err_q;

endmodule

// File: tb/tb_npc_mem_resp.sv
// Directed bench for npc_mem_resp: three instances at READ_LATENCY 1, 3 and 4,
// one selected at a time through a shared stimulus bus.
module tb_npc_mem_resp;
  import npc_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int          sel;
  logic        rom_ce, mem_ce, mem_we;
  logic [63:0] pc, raddr, waddr, wdata;
  int          total = 0;
  int          bad   = 0;

  npc_mem_resp_if b0 ();
  npc_mem_resp_if b1 ();
  npc_mem_resp_if b2 ();

  npc_mem_resp #(.ADDR_W(12), .READ_LATENCY(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  npc_mem_resp #(.ADDR_W(12), .READ_LATENCY(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  npc_mem_resp #(.ADDR_W(12), .READ_LATENCY(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  assign b0.rom_ce = rom_ce && (sel == 0);
  assign b1.rom_ce = rom_ce && (sel == 1);
  assign b2.rom_ce = rom_ce && (sel == 2);
  assign b0.mem_ce = mem_ce && (sel == 0);
  assign b1.mem_ce = mem_ce && (sel == 1);
  assign b2.mem_ce = mem_ce && (sel == 2);
  assign b0.pc = pc;        assign b1.pc = pc;        assign b2.pc = pc;
  assign b0.mem_we = mem_we; assign b1.mem_we = mem_we; assign b2.mem_we = mem_we;
  assign b0.mem_raddr = raddr; assign b1.mem_raddr = raddr; assign b2.mem_raddr = raddr;
  assign b0.mem_waddr = waddr; assign b1.mem_waddr = waddr; assign b2.mem_waddr = waddr;
  assign b0.mem_wdata = wdata; assign b1.mem_wdata = wdata; assign b2.mem_wdata = wdata;

  logic [31:0] inst;
  logic [63:0] rdata;
  logic        hold, err;
  assign inst  = (sel == 0) ? b0.inst      : (sel == 1) ? b1.inst      : b2.inst;
  assign rdata = (sel == 0) ? b0.mem_rdata : (sel == 1) ? b1.mem_rdata : b2.mem_rdata;
  assign hold  = (sel == 0) ? b0.hold_o    : (sel == 1) ? b1.hold_o    : b2.hold_o;
  assign err   = (sel == 0) ? b0.addr_err_o : (sel == 1) ? b1.addr_err_o : b2.addr_err_o;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [63:0] a, input logic [63:0] d);
    mem_ce = 1'b1; mem_we = 1'b1; waddr = a; wdata = d;
    tick();
    mem_ce = 1'b0; mem_we = 1'b0;
  endtask

  // Request a load, count stall cycles (bounded), then check data in the DONE cycle.
  task automatic load(input string tag, input logic [63:0] a, input logic [63:0] exp,
                      input int exp_hold, input logic [63:0] alt);
    int  n;
    logic stalled;
    n = 0;
    mem_ce = 1'b1; mem_we = 1'b0; raddr = a;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      stalled = hold;
      if (!stalled) break;
      n++;
      if (n == 2) raddr = alt;
      tick();
    end
    chk({tag, "_holdcnt"}, 64'(n), 64'(exp_hold));
    chk({tag, "_data"}, rdata, exp);
    chk({tag, "_err"}, 64'(err), 64'd0);
    tick();
    mem_ce = 1'b0;
  endtask

  initial begin
    sel = 0; rom_ce = 1'b0; pc = '0; mem_we = 1'b0; wdata = '0; waddr = '0;
    rst_n = 1'b0; mem_ce = 1'b1; raddr = 64'h8000_0010;
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_hold", 64'(hold), 64'd0);
      chk("rst_rdata", rdata, 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      tick();
    end
    mem_ce = 1'b0; rst_n = 1'b1;
    tick();

    // Latency 1: store then load
    store(64'h8000_0010, 64'hDEAD_BEEF_0123_4567);
    load("rl1", 64'h8000_0010, 64'hDEAD_BEEF_0123_4567, 2, 64'h8000_0010);

    store(64'h8000_0000, 64'h0010_0093_0000_0013);
    rom_ce = 1'b1; pc = 64'h8000_0000; #1;
    chk("fetch_lo", 64'(inst), 64'h0000_0013);
    pc = 64'h8000_0004; #1;
    chk("fetch_hi", 64'(inst), 64'h0010_0093);
    rom_ce = 1'b0; #1;
    chk("fetch_off", 64'(inst), 64'h0);
    rom_ce = 1'b1; pc = 64'h7FFF_FFFC; #1;
    chk("fetch_oor", 64'(inst), 64'h0);
    rom_ce = 1'b0;

    // Out-of-range load
    mem_ce = 1'b1; mem_we = 1'b0; raddr = 64'h7FFF_FFF8;
    @(negedge clk);
    chk("oorld_hold", 64'(hold), 64'd0);
    tick();
    mem_ce = 1'b0;
    @(negedge clk);
    chk("oorld_err", 64'(err), 64'd1);
    chk("oorld_rdata", rdata, 64'd0);
    tick();
    @(negedge clk);
    chk("oorld_err_end", 64'(err), 64'd0);

    // Out-of-range store just past the top of the array
    tick();
    mem_ce = 1'b1; mem_we = 1'b1; waddr = 64'h8000_8000; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    chk("oorst_hold", 64'(hold), 64'd0);
    tick();
    mem_ce = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    chk("oorst_err", 64'(err), 64'd1);
    tick();
    @(negedge clk);
    chk("oorst_err_end", 64'(err), 64'd0);
    rom_ce = 1'b1; pc = 64'h8000_0000; #1;
    chk("oorst_w0_lo", 64'(inst), 64'h0000_0013);
    pc = 64'h8000_0004; #1;
    chk("oorst_w0_hi", 64'(inst), 64'h0010_0093);
    rom_ce = 1'b0;
    tick();

    // Latency 4 with address change during WAIT
    sel = 2;
    store(64'h8000_0020, 64'h1111_2222_3333_4444);
    store(64'h8000_0028, 64'h5555_6666_7777_8888);
    load("rl4", 64'h8000_0020, 64'h1111_2222_3333_4444, 5, 64'h8000_0028);

    // Latency 3: normal load, then reset in the 2nd WAIT cycle
    sel = 1;
    store(64'h8000_0030, 64'hCAFE_F00D_AAAA_5555);
    load("rl3", 64'h8000_0030, 64'hCAFE_F00D_AAAA_5555, 4, 64'h8000_0030);
    mem_ce = 1'b1; mem_we = 1'b0; raddr = 64'h8000_0030;
    @(negedge clk);
    chk("midrst_req_hold", 64'(hold), 64'd1);
    tick();
    @(negedge clk);
    chk("midrst_w1_hold", 64'(hold), 64'd1);
    tick();
    rst_n = 1'b0; mem_ce = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_hold", 64'(hold), 64'd0);
    chk("midrst_rdata", rdata, 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    tick();
    load("rl3_after", 64'h8000_0030, 64'hCAFE_F00D_AAAA_5555, 4, 64'h8000_0030);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
